// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes per downstream stage and produces the D-stage
// stall, rs/rt forwarding selects and mul/div busy window. Define HAZARD_STATS_EN for the stall counter.
module hazard_scoreboard #(
  parameter int STAGES      = 3,
  parameter int REG_W       = 5,
  parameter int MUL_LATENCY = 5,
  localparam int SEL_W      = $clog2(STAGES + 1),
  localparam int STG_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [STG_W-1:0] d_rs_need,
  input  logic [REG_W-1:0] d_rt,
  input  logic [STG_W-1:0] d_rt_need,
  input  logic [REG_W-1:0] d_dest,
  input  logic [STG_W-1:0] d_ready,
  input  logic             d_mul_start,
  input  logic             d_mul_use,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs,
  output logic [SEL_W-1:0] fwd_rt,
  output logic             mul_busy,
  output logic [31:0]      stall_count
);

  logic [STAGES:1]            vld_q, vld_d;
  logic [STAGES:1][REG_W-1:0] dest_q, dest_d;
  logic [STAGES:1][STG_W-1:0] rdy_q, rdy_d;
  logic [7:0]                 mul_cnt_q, mul_cnt_d;
  logic [STG_W-1:0]           rdy_norm;
  logic [SEL_W:0]             rs_eval, rt_eval;
  logic                       mul_haz;

  // Returns {hazard, fwd_sel} for one source; the loop runs oldest to youngest so the youngest match wins.
  function automatic logic [SEL_W:0] src_eval(input logic [REG_W-1:0] src,
                                              input logic [STG_W-1:0] need);
    int               k_hit;
    logic [STG_W-1:0] r_hit;
    logic             haz;
    logic [SEL_W-1:0] fwd;
    k_hit = 0;
    r_hit = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (src != '0 && vld_q[k] && dest_q[k] == src) begin
        k_hit = k;
        r_hit = rdy_q[k];
      end
    end
    haz = (k_hit != 0) && (k_hit + int'(need) <= int'(r_hit));
    fwd = (k_hit != 0 && k_hit > int'(r_hit)) ? SEL_W'(k_hit) : '0;
    return {haz, fwd};
  endfunction

  always_comb begin
    rs_eval  = src_eval(d_rs, d_rs_need);
    rt_eval  = src_eval(d_rt, d_rt_need);
    mul_haz  = d_mul_use && (mul_cnt_q != 8'd0);
    stall    = d_valid && (rs_eval[SEL_W] || rt_eval[SEL_W] || mul_haz);
    fwd_rs   = rs_eval[SEL_W-1:0];
    fwd_rt   = rt_eval[SEL_W-1:0];
    mul_busy = (mul_cnt_q != 8'd0);
  end

  always_comb begin
    vld_d  = '0;
    dest_d = '0;
    rdy_d  = '0;
    // A ready stage of 0 or beyond the tracked window means the value only exists at retirement.
    rdy_norm = d_ready;
    if (d_ready == '0 || int'(d_ready) > STAGES) rdy_norm = STG_W'(STAGES);
    vld_d[1]  = d_valid && !stall && (d_dest != '0);
    dest_d[1] = d_dest;
    rdy_d[1]  = rdy_norm;
    for (int k = 2; k <= STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      dest_d[k] = dest_q[k-1];
      rdy_d[k]  = rdy_q[k-1];
    end
    mul_cnt_d = mul_cnt_q;
    if (d_valid && d_mul_start && !stall) mul_cnt_d = 8'(MUL_LATENCY);
    else if (mul_cnt_q != 8'd0)           mul_cnt_d = mul_cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      dest_q    <= '0;
      rdy_q     <= '0;
      mul_cnt_q <= 8'd0;
    end else begin
      vld_q     <= vld_d;
      dest_q    <= dest_d;
      rdy_q     <= rdy_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_count_q <= 32'd0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule
